// File: rtl/truth_table_gen_pkg.sv
// -----------------------------------------------------------------------------
// tt_pkg : shared definitions for the truth-table generator slice.
//   - MODE_* : run-time function select codes (6 and 7 are reserved, output 0)
//   - N_MAX  : largest supported number of function inputs
//   - state_e: sweep sequencer states
//   - odd_parity(): parity helper used by the XOR/XNOR functions
// -----------------------------------------------------------------------------
package tt_pkg;

   localparam logic [2:0] MODE_NOR  = 3'd0;
   localparam logic [2:0] MODE_OR   = 3'd1;
   localparam logic [2:0] MODE_NAND = 3'd2;
   localparam logic [2:0] MODE_AND  = 3'd3;
   localparam logic [2:0] MODE_XOR  = 3'd4;
   localparam logic [2:0] MODE_XNOR = 3'd5;

   localparam int N_MAX = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Odd parity of a zero-extended input word (1 when an odd number of bits set).
   function automatic logic odd_parity(input logic [N_MAX-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/truth_table_gen_if.sv
// -----------------------------------------------------------------------------
// truth_table_gen_if : request/result bundle of the truth-table generator.
//   start     : request a sweep (only honoured while the generator is idle)
//   mode      : function select, captured when a start is accepted
//   busy      : sweep or done phase in progress
//   valid     : m and s carry a live minterm/output pair
//   m         : current minterm index, bit N-1 is the leftmost input
//   s         : function output for m, forced low when valid is low
//   done      : one-cycle pulse once the last minterm has been recorded
//   truth_tbl : accumulated table, bit i = f(i). Named truth_tbl because
//               "table" is a reserved word in SystemVerilog.
// master = requester (drives start/mode), slave = generator.
// -----------------------------------------------------------------------------
interface truth_table_gen_if #(
   parameter int N = 2
) ();

   localparam int W = 1 << N;

   logic         start;
   logic [2:0]   mode;
   logic         busy;
   logic         valid;
   logic [N-1:0] m;
   logic         s;
   logic         done;
   logic [W-1:0] truth_tbl;

   modport master (
      output start, mode,
      input  busy, valid, m, s, done, truth_tbl
   );

   modport slave (
      input  start, mode,
      output busy, valid, m, s, done, truth_tbl
   );

endinterface

// File: rtl/truth_table_gen_nfunc.sv
// -----------------------------------------------------------------------------
// nfunc : combinational N-input reducing gate with run-time mode select.
//   s    : output f(x) for the selected mode
//   mode : MODE_NOR..MODE_XNOR, reserved codes give 0
//   x    : N-bit input vector
// -----------------------------------------------------------------------------
module nfunc
   import tt_pkg::*;
#(
   parameter int N = 2
) (
   output logic         s,
   input  logic [2:0]   mode,
   input  logic [N-1:0] x
);

   logic [N_MAX-1:0] x_ext_s;

   // Zero-extend the input to the parity helper's fixed width.
   always_comb begin
      x_ext_s        = '0;
      x_ext_s[N-1:0] = x;
   end

   // Mode decode onto N-input reductions; reserved codes are forced low.
   always_comb begin
      s = 1'b0;
      case (mode)
         MODE_NOR:  s = ~(|x);
         MODE_OR:   s = |x;
         MODE_NAND: s = ~(&x);
         MODE_AND:  s = &x;
         MODE_XOR:  s = odd_parity(x_ext_s);
         MODE_XNOR: s = ~odd_parity(x_ext_s);
         default:   s = 1'b0;
      endcase
   end

endmodule

// File: rtl/truth_table_gen.sv
// -----------------------------------------------------------------------------
// truth_table_gen : on start, sweeps all 2**N minterms of the selected Boolean
// function, streaming one (m, s) pair per cycle and building the full truth
// table, then pulses done for one cycle.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, aborts any sweep
//   bus   : truth_table_gen_if slave modport (start, mode in; busy, valid,
//           m, s, done, truth_tbl out)
// -----------------------------------------------------------------------------
module truth_table_gen
   import tt_pkg::*;
#(
   parameter int N = 2
) (
   input  logic              clk,
   input  logic              reset,
   truth_table_gen_if.slave  bus
);

   localparam int W = 1 << N;

   localparam logic [1:0]   ST_IDLE  = IDLE;
   localparam logic [1:0]   ST_SWEEP = SWEEP;
   localparam logic [1:0]   ST_DONE  = DONE;

   localparam logic [N-1:0] M_LAST = {N{1'b1}};
   localparam logic [N-1:0] M_ONE  = N'(1);

   logic [1:0]   state_r;
   logic [1:0]   next_state_s;
   logic [N-1:0] m_r;
   logic [2:0]   mode_r;
   logic [W-1:0] tbl_r;
   logic         busy_r;
   logic         valid_r;
   logic         done_r;
   logic         f_s;

   nfunc #(.N(N)) u_nfunc (
      .s    (f_s),
      .mode (mode_r),
      .x    (m_r)
   );

   // Next-state decode; any unexpected encoding falls back to IDLE.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               next_state_s = ST_SWEEP;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_SWEEP: begin
            if (m_r == M_LAST) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_SWEEP;
            end
         end
         ST_DONE: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register; status flags are registered from the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s != ST_IDLE);
         valid_r <= (next_state_s == ST_SWEEP);
         done_r  <= (next_state_s == ST_DONE);
      end
   end

   // Minterm counter, captured mode and table accumulation. The counter
   // parks on the last minterm instead of wrapping, so m reads W-1 in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_r    <= '0;
         mode_r <= 3'd0;
         tbl_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  mode_r <= bus.mode;
                  m_r    <= '0;
                  tbl_r  <= '0;
               end else begin
                  mode_r <= mode_r;
                  m_r    <= m_r;
                  tbl_r  <= tbl_r;
               end
            end
            ST_SWEEP: begin
               tbl_r[m_r] <= f_s;
               if (m_r != M_LAST) begin
                  m_r <= m_r + M_ONE;
               end else begin
                  m_r <= m_r;
               end
            end
            ST_DONE: begin
               m_r <= m_r;
            end
            default: begin
               m_r <= m_r;
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.valid     = valid_r;
   assign bus.done      = done_r;
   assign bus.m         = m_r;
   assign bus.truth_tbl = tbl_r;
   // Function output is only meaningful during the sweep.
   assign bus.s         = valid_r & f_s;

endmodule

// File: tb/tb_truth_table_gen.sv
// -----------------------------------------------------------------------------
// tb_truth_table_gen : bench for truth_table_gen. Three generators (N=1,2,3)
// share clk/reset/start/mode; `sel` picks which one is observed.
// -----------------------------------------------------------------------------
module tb_truth_table_gen;
   import tt_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] mode;
   int         chk_cnt  = 0;
   int         pass_cnt = 0;
   int         sel      = 2;

   always #5 clk = ~clk;

   truth_table_gen_if #(.N(1)) if1 ();
   truth_table_gen_if #(.N(2)) if2 ();
   truth_table_gen_if #(.N(3)) if3 ();

   assign if1.start = start;  assign if1.mode = mode;
   assign if2.start = start;  assign if2.mode = mode;
   assign if3.start = start;  assign if3.mode = mode;

   truth_table_gen #(.N(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   truth_table_gen #(.N(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
   truth_table_gen #(.N(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

   logic        obs_busy, obs_valid, obs_s, obs_done;
   logic [4:0]  obs_m;
   logic [31:0] obs_tbl;

   always_comb begin
      obs_busy = 1'b0; obs_valid = 1'b0; obs_s = 1'b0; obs_done = 1'b0;
      obs_m = 5'd0; obs_tbl = 32'd0;
      case (sel)
         1: begin
            obs_busy = if1.busy; obs_valid = if1.valid; obs_s = if1.s; obs_done = if1.done;
            obs_m[0:0] = if1.m; obs_tbl[1:0] = if1.truth_tbl;
         end
         2: begin
            obs_busy = if2.busy; obs_valid = if2.valid; obs_s = if2.s; obs_done = if2.done;
            obs_m[1:0] = if2.m; obs_tbl[3:0] = if2.truth_tbl;
         end
         default: begin
            obs_busy = if3.busy; obs_valid = if3.valid; obs_s = if3.s; obs_done = if3.done;
            obs_m[2:0] = if3.m; obs_tbl[7:0] = if3.truth_tbl;
         end
      endcase
   end

   // Reference: function value of minterm i from the Boolean definitions.
   function automatic logic ref_bit(input logic [2:0] md, input int i, input int n);
      int w;
      int ones;
      w = 1 << n;
      ones = 0;
      for (int b = 0; b < n; b++) ones += (i >> b) & 1;
      case (md)
         3'd0:    return (i == 0);
         3'd1:    return (i != 0);
         3'd2:    return (i != w - 1);
         3'd3:    return (i == w - 1);
         3'd4:    return (ones % 2 == 1);
         3'd5:    return (ones % 2 == 0);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_table(input logic [2:0] md, input int n);
      logic [31:0] t;
      t = 32'd0;
      for (int i = 0; i < (1 << n); i++) t[i] = ref_bit(md, i, n);
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      start = 1'b0;
      repeat (12) tick();
   endtask

   task automatic check_idle_zero(input string tag);
      chk_cnt++; if (obs_busy !== 1'b0) $display("FAIL %s busy got=%b want=0", tag, obs_busy); else pass_cnt++;
      chk_cnt++; if (obs_valid !== 1'b0) $display("FAIL %s valid got=%b want=0", tag, obs_valid); else pass_cnt++;
      chk_cnt++; if (obs_s !== 1'b0) $display("FAIL %s s got=%b want=0", tag, obs_s); else pass_cnt++;
      chk_cnt++; if (obs_done !== 1'b0) $display("FAIL %s done got=%b want=0", tag, obs_done); else pass_cnt++;
      chk_cnt++; if (obs_m !== 5'd0) $display("FAIL %s m got=%0d want=0", tag, obs_m); else pass_cnt++;
      chk_cnt++; if (obs_tbl !== 32'd0) $display("FAIL %s table got=%h want=0", tag, obs_tbl); else pass_cnt++;
   endtask

   // One full sweep from IDLE, checking every cycle against the model.
   // mode is scrambled during the sweep; it must have no effect.
   task automatic run_sweep(input int n, input logic [2:0] md, input string tag,
                            output logic [31:0] got);
      int w;
      logic [31:0] exp_tbl;
      w = 1 << n;
      exp_tbl = ref_table(md, n);
      start = 1'b1; mode = md;
      tick();
      start = 1'b0;
      for (int i = 0; i < w; i++) begin
         chk_cnt++; if (obs_valid !== 1'b1) $display("FAIL %s valid i=%0d got=%b want=1", tag, i, obs_valid); else pass_cnt++;
         chk_cnt++; if (obs_busy !== 1'b1) $display("FAIL %s busy i=%0d got=%b want=1", tag, i, obs_busy); else pass_cnt++;
         chk_cnt++; if (obs_done !== 1'b0) $display("FAIL %s done i=%0d got=%b want=0", tag, i, obs_done); else pass_cnt++;
         chk_cnt++; if (obs_m !== 5'(i)) $display("FAIL %s m got=%0d want=%0d", tag, obs_m, i); else pass_cnt++;
         chk_cnt++; if (obs_s !== ref_bit(md, i, n)) $display("FAIL %s s i=%0d got=%b want=%b", tag, i, obs_s, ref_bit(md, i, n)); else pass_cnt++;
         mode = 3'($urandom);
         tick();
      end
      chk_cnt++; if (obs_done !== 1'b1) $display("FAIL %s done-pulse got=%b want=1", tag, obs_done); else pass_cnt++;
      chk_cnt++; if (obs_busy !== 1'b1) $display("FAIL %s busy-in-done got=%b want=1", tag, obs_busy); else pass_cnt++;
      chk_cnt++; if (obs_valid !== 1'b0) $display("FAIL %s valid-in-done got=%b want=0", tag, obs_valid); else pass_cnt++;
      chk_cnt++; if (obs_s !== 1'b0) $display("FAIL %s s-in-done got=%b want=0", tag, obs_s); else pass_cnt++;
      chk_cnt++; if (obs_m !== 5'(w - 1)) $display("FAIL %s m-in-done got=%0d want=%0d", tag, obs_m, w - 1); else pass_cnt++;
      chk_cnt++; if (obs_tbl !== exp_tbl) $display("FAIL %s table-at-done got=%h want=%h", tag, obs_tbl, exp_tbl); else pass_cnt++;
      got = obs_tbl;
      tick();
      chk_cnt++; if (obs_done !== 1'b0) $display("FAIL %s done-after got=%b want=0", tag, obs_done); else pass_cnt++;
      chk_cnt++; if (obs_busy !== 1'b0) $display("FAIL %s busy-after got=%b want=0", tag, obs_busy); else pass_cnt++;
      chk_cnt++; if (obs_tbl !== exp_tbl) $display("FAIL %s table-hold got=%h want=%h", tag, obs_tbl, exp_tbl); else pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; mode = MODE_OR;
      repeat (3) tick();
      for (int k = 1; k <= 3; k++) begin
         sel = k; #1;
         check_idle_zero("reset");
      end
      start = 1'b0; reset = 1'b0;
      tick();
      sel = 2; #1;
      check_idle_zero("reset-release");
   endtask

   task automatic test_nor_n2();
      logic [31:0] got;
      sel = 2;
      run_sweep(2, MODE_NOR, "nor2", got);
      chk_cnt++; if (got[3:0] !== 4'b0001) $display("FAIL nor2 table got=%b want=0001", got[3:0]); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] got;
      logic [3:0]  exp_lit [5];
      exp_lit = '{4'b1110, 4'b0111, 4'b1000, 4'b0110, 4'b1001};
      sel = 2;
      for (int k = 0; k < 5; k++) begin
         run_sweep(2, 3'(k + 1), "b2b", got);
         chk_cnt++; if (got[3:0] !== exp_lit[k]) $display("FAIL b2b mode=%0d table got=%b want=%b", k + 1, got[3:0], exp_lit[k]); else pass_cnt++;
      end
   endtask

   task automatic test_n3();
      logic [31:0] got;
      settle();
      sel = 3;
      run_sweep(3, MODE_XOR, "xor3", got);
      chk_cnt++; if (got[7:0] !== 8'b10010110) $display("FAIL xor3 table got=%b want=10010110", got[7:0]); else pass_cnt++;
      run_sweep(3, 3'd6, "rsv3", got);
      chk_cnt++; if (got[7:0] !== 8'h00) $display("FAIL rsv3 table got=%h want=00", got[7:0]); else pass_cnt++;
   endtask

   task automatic test_n1();
      logic [31:0] got;
      settle();
      sel = 1;
      for (int k = 0; k < 8; k++) run_sweep(1, 3'(k), "n1", got);
   endtask

   // Start held high: busy pattern 5 high / 1 low repeating, done on 5th cycle.
   task automatic test_start_held();
      settle();
      sel = 2; mode = MODE_NOR; start = 1'b1;
      for (int c = 0; c < 18; c++) begin
         tick();
         chk_cnt++; if (obs_busy !== ((c % 6) != 5)) $display("FAIL held busy c=%0d got=%b", c, obs_busy); else pass_cnt++;
         chk_cnt++; if (obs_done !== ((c % 6) == 4)) $display("FAIL held done c=%0d got=%b", c, obs_done); else pass_cnt++;
         chk_cnt++; if (obs_valid !== ((c % 6) < 4)) $display("FAIL held valid c=%0d got=%b", c, obs_valid); else pass_cnt++;
      end
      settle();
   endtask

   task automatic test_reset_mid();
      logic [31:0] got;
      settle();
      sel = 2; mode = MODE_NOR; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      chk_cnt++; if (obs_m !== 5'd2) $display("FAIL rstmid pre m got=%0d want=2", obs_m); else pass_cnt++;
      reset = 1'b1; start = 1'b1;
      tick();
      check_idle_zero("rstmid");
      reset = 1'b0; start = 1'b0;
      tick();
      chk_cnt++; if (obs_busy !== 1'b0) $display("FAIL rstmid no-queue busy got=%b want=0", obs_busy); else pass_cnt++;
      run_sweep(2, MODE_NOR, "rstmid-fresh", got);
      chk_cnt++; if (got[3:0] !== 4'b0001) $display("FAIL rstmid table got=%b want=0001", got[3:0]); else pass_cnt++;
   endtask

   task automatic test_mode_toggle();
      logic [31:0] got;
      sel = 2;
      run_sweep(2, MODE_AND, "toggle", got);
      chk_cnt++; if (got[3:0] !== 4'b1000) $display("FAIL toggle table got=%b want=1000", got[3:0]); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [31:0] got;
      for (int r = 0; r < 12; r++) begin
         settle();
         sel = $urandom_range(3, 1);
         run_sweep(sel, 3'($urandom), "rand", got);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 3'd0;
      test_reset();
      test_nor_n2();
      test_back_to_back();
      test_n3();
      test_n1();
      test_start_held();
      test_reset_mid();
      test_mode_toggle();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
